mul_seq_24bit: RTL and testbench

//   Iterative 24-bit unsigned shift-and-add multiplier; one partial product per clock.

---
 rtl/mul_seq_24bit.sv | 105 ++++++++++
 tb/tb_mul_seq_24bit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_24bit.sv
// Iterative 24-bit unsigned shift-and-add multiplier; one partial product per clock through an external CLA adder.
// Vectors are [WIDTH-1:0]; the upstream MSB-first numbering (bit 0 = MSB) maps to index WIDTH-1 here.
module mul_seq_24bit #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p_hi,
  output logic [WIDTH-1:0] p_lo,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mcand_q <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update; the adder carry becomes the new product MSB
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        hi_d  = {add_cout, add_s[WIDTH-1:1]};
        lo_d  = {add_s[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: status from state, adder operands from the running product
  always_comb begin
    busy    = (state_q == ST_RUN);
    done    = (state_q == ST_DONE);
    p_hi    = hi_q;
    p_lo    = lo_q;
    add_a   = hi_q;
    add_cin = 1'b0;
    if ((state_q == ST_RUN) && lo_q[0]) begin
      add_b = mcand_q;
    end else begin
      add_b = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_mul_seq_24bit.sv
// Directed self-checking bench for mul_seq_24bit; the external CLA adder is modelled behaviourally here.
module tb_mul_seq_24bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] a, b;
  logic        busy, done;
  logic [23:0] p_hi, p_lo;
  logic [23:0] add_a, add_b;
  logic        add_cin;
  logic [23:0] add_s;
  logic        add_cout;

  int n_cmp = 0;
  int n_err = 0;

  mul_seq_24bit #(.WIDTH(24), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .p_hi     (p_hi),
    .p_lo     (p_lo),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {24'd0, add_cin};

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called one cycle after start acceptance; follows the op to its done pulse and one cycle beyond.
  task automatic wait_done(input string tag, input logic [47:0] exp);
    int nbusy;
    int ncyc;
    logic seen;
    nbusy = 0;
    ncyc  = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
      ncyc++;
      tick();
    end
    check_val({tag, "_done_seen"}, 48'(seen), 48'd1);
    check_val({tag, "_busy_cycles"}, 48'(nbusy), 48'd24);
    check_val({tag, "_latency"}, 48'(ncyc), 48'd24);
    check_val({tag, "_product"}, {p_hi, p_lo}, exp);
    tick();
    check_val({tag, "_done_pulse"}, 48'(done), 48'd0);
    check_val({tag, "_hold"}, {p_hi, p_lo}, exp);
  endtask

  task automatic run_op(input logic [23:0] ta, input logic [23:0] tb, input logic [47:0] exp,
                        input string tag);
    a     = ta;
    b     = tb;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(tag, exp);
  endtask

  initial begin
    int ndone;
    rst   = 1'b1;
    start = 1'b1;
    a     = 24'hFFFFFF;
    b     = 24'hFFFFFF;
    tick();
    tick();
    check_val("rst_busy", 48'(busy), 48'd0);
    check_val("rst_done", 48'(done), 48'd0);
    check_val("rst_prod", {p_hi, p_lo}, 48'd0);
    check_val("rst_add_b", 48'(add_b), 48'd0);
    check_val("rst_add_cin", 48'(add_cin), 48'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check_val("idle_busy", 48'(busy), 48'd0);

    // T1..T3
    run_op(24'h000000, 24'h000000, 48'h000000_000000, "t1");
    run_op(24'h00000A, 24'h000005, 48'h000000_000032, "t2");
    run_op(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE_000001, "t3");

    // T4: start held high through the first op; the second op is taken from the next IDLE cycle
    a     = 24'hFFFFFF;
    b     = 24'h000001;
    start = 1'b1;
    tick();
    a = 24'h000002;
    b = 24'h000003;
    check_val("t4_add_cin_run", 48'(add_cin), 48'd0);
    wait_done("t4a", 48'h000000_FFFFFF);
    check_val("t4_ignored_in_done", 48'(busy), 48'd0);
    tick();
    check_val("t4_accept_idle", 48'(busy), 48'd1);
    start = 1'b0;
    a     = 24'h777777;
    b     = 24'h555555;
    wait_done("t4b", 48'h000000_000006);

    // T5: second start pulse during RUN is ignored
    a     = 24'h123456;
    b     = 24'h000010;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    a     = 24'h00FFFF;
    b     = 24'h00FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("t5_busy_mid", 48'(busy), 48'd1);
    begin
      int nb;
      int nc;
      nb = 0;
      nc = 0;
      for (int i = 0; i < 40; i++) begin
        if (done) break;
        nc++;
        tick();
      end
      nb = nc + 5;
      check_val("t5_latency", 48'(nb), 48'd24);
    end
    check_val("t5_product", {p_hi, p_lo}, 48'h000001_234560);
    tick();
    check_val("t5_done_pulse", 48'(done), 48'd0);

    // T6: mid-run reset aborts with no done pulse
    a     = 24'h00000A;
    b     = 24'h000005;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6_busy", 48'(busy), 48'd0);
    check_val("t6_done", 48'(done), 48'd0);
    check_val("t6_prod", {p_hi, p_lo}, 48'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      tick();
    end
    check_val("t6_no_done", 48'(ndone), 48'd0);
    run_op(24'h00000A, 24'h000005, 48'h000000_000032, "t6r");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
